// File: rtl/jk_updown_counter_if.sv
// Control and observation bundle for the JK-flop mod-N up/down counter.
// The master side drives count controls; the slave side is the counter itself.
interface jk_updown_counter_if #(
   parameter int WIDTH = 4
);
   logic             En;
   logic             Up;
   logic             Load;
   logic [WIDTH-1:0] D;
   logic [WIDTH-1:0] Q;
   logic [WIDTH-1:0] Jv;
   logic [WIDTH-1:0] Kv;
   logic             Tc;
   logic             Ovf;

   modport master (
      output En, Up, Load, D,
      input  Q, Jv, Kv, Tc, Ovf
   );

   modport slave (
      input  En, Up, Load, D,
      output Q, Jv, Kv, Tc, Ovf
   );
endinterface

// File: rtl/jk_updown_counter.sv
// Mod-N up/down counter built from a bank of JK flops; exports the per-bit
// J/K excitation so the flop bank can be checked against the count state.
module jk_updown_counter #(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 10
) (
   input  logic                 Clk,
   input  logic                 Resetn,
   jk_updown_counter_if.slave   bus
);

   if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
      $error("jk_updown_counter: MODULUS must lie in 2..2**WIDTH");
   end

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] n_d;
   logic [WIDTH-1:0] jv_d;
   logic [WIDTH-1:0] kv_d;
   logic             ovf_q;
   logic             ovf_d;
   logic             tc_d;

   // Terminal count marks the cycle whose edge will wrap the count.
   always_comb begin
      tc_d = 1'b0;
      if (bus.En && !bus.Load) begin
         tc_d = bus.Up ? (q_q == MAX_VAL) : (q_q == '0);
      end
   end

   // Target value for the next edge; load clamps out-of-range data.
   always_comb begin
      n_d = q_q;
      if (bus.Load) begin
         n_d = ({1'b0, bus.D} < MOD_EXT) ? bus.D : MAX_VAL;
      end else if (bus.En && bus.Up) begin
         n_d = (q_q == MAX_VAL) ? '0 : q_q + WIDTH'(1);
      end else if (bus.En) begin
         n_d = (q_q == '0) ? MAX_VAL : q_q - WIDTH'(1);
      end
   end

   // Minimal excitation with don't-cares forced to 0: set only on 0->1,
   // clear only on 1->0, so a hold produces all-zero J and K.
   always_comb begin
      jv_d = ~q_q & n_d;
      kv_d = q_q & ~n_d;
   end

   // Sticky wrap flag; a load always wins over a coincident wrap.
   always_comb begin
      ovf_d = ovf_q;
      if (bus.Load) begin
         ovf_d = 1'b0;
      end else if (tc_d) begin
         ovf_d = 1'b1;
      end
   end

   // JK flop bank, full truth table including toggle on J=K=1.
   always_ff @(posedge Clk or negedge Resetn) begin
      if (!Resetn) begin
         q_q <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            case ({jv_d[i], kv_d[i]})
               2'b10:   q_q[i] <= 1'b1;
               2'b01:   q_q[i] <= 1'b0;
               2'b11:   q_q[i] <= ~q_q[i];
               default: q_q[i] <= q_q[i];
            endcase
         end
      end
   end

   always_ff @(posedge Clk or negedge Resetn) begin
      if (!Resetn) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign bus.Q   = q_q;
   assign bus.Jv  = jv_d;
   assign bus.Kv  = kv_d;
   assign bus.Tc  = tc_d;
   assign bus.Ovf = ovf_q;

endmodule

// File: tb/tb_jk_updown_counter.sv
// Bench for jk_updown_counter: a mod-10 4-bit instance and a full-range
// mod-8 3-bit instance share controls and are checked against integer models.
module tb_jk_updown_counter;

   logic Clk;
   logic Resetn;

   jk_updown_counter_if #(.WIDTH(4)) busA ();
   jk_updown_counter_if #(.WIDTH(3)) busB ();

   jk_updown_counter #(.WIDTH(4), .MODULUS(10)) dutA (
      .Clk    (Clk),
      .Resetn (Resetn),
      .bus    (busA.slave)
   );

   jk_updown_counter #(.WIDTH(3), .MODULUS(8)) dutB (
      .Clk    (Clk),
      .Resetn (Resetn),
      .bus    (busB.slave)
   );

   int compared   = 0;
   int mismatched = 0;

   int qA = 0, ovA = 0;
   int qB = 0, ovB = 0;

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Single comparison point; every check is counted here.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t",
                  tag, observed, expected, $time);
      end
   endtask

   function automatic int modelNext(int q, int m, bit en, bit up, bit load, int d);
      if (load)   return (d < m) ? d : m - 1;
      if (en && up) return (q + 1) % m;
      if (en)     return (q + m - 1) % m;
      return q;
   endfunction

   function automatic bit modelWrap(int q, int m, bit en, bit up, bit load);
      if (!en || load) return 1'b0;
      return up ? (q + 1 == m) : (q == 0);
   endfunction

   // Excitation from the per-bit transition table (0->1 sets, 1->0 clears).
   function automatic int modelExc(int q, int n, int w, bit wantJ);
      int r = 0;
      for (int i = 0; i < w; i++) begin
         if (wantJ && !q[i] && n[i]) r |= (1 << i);
         if (!wantJ && q[i] && !n[i]) r |= (1 << i);
      end
      return r;
   endfunction

   task automatic compareAll(input bit en, input bit up, input bit load, input int d);
      int nA, nB;
      nA = modelNext(qA, 10, en, up, load, d);
      nB = modelNext(qB, 8, en, up, load, d & 7);
      checkOutput("A.Q",   busA.Q,   qA);
      checkOutput("A.Ovf", busA.Ovf, ovA);
      checkOutput("A.Tc",  busA.Tc,  modelWrap(qA, 10, en, up, load));
      checkOutput("A.Jv",  busA.Jv,  modelExc(qA, nA, 4, 1'b1));
      checkOutput("A.Kv",  busA.Kv,  modelExc(qA, nA, 4, 1'b0));
      checkOutput("B.Q",   busB.Q,   qB);
      checkOutput("B.Ovf", busB.Ovf, ovB);
      checkOutput("B.Tc",  busB.Tc,  modelWrap(qB, 8, en, up, load));
      checkOutput("B.Jv",  busB.Jv,  modelExc(qB, nB, 3, 1'b1));
      checkOutput("B.Kv",  busB.Kv,  modelExc(qB, nB, 3, 1'b0));
   endtask

   // Called at a falling edge: drive, check before the rising edge, advance models.
   task automatic applyStimulus(input bit en, input bit up, input bit load, input int d);
      busA.En = en;  busA.Up = up;  busA.Load = load;  busA.D = 4'(d);
      busB.En = en;  busB.Up = up;  busB.Load = load;  busB.D = 3'(d & 7);
      #1;
      compareAll(en, up, load, d);
      @(posedge Clk);
      if (load)                            ovA = 0;
      else if (modelWrap(qA, 10, en, up, load)) ovA = 1;
      if (load)                            ovB = 0;
      else if (modelWrap(qB, 8, en, up, load))  ovB = 1;
      qA = modelNext(qA, 10, en, up, load, d);
      qB = modelNext(qB, 8, en, up, load, d & 7);
      @(negedge Clk);
   endtask

   // Mid-cycle reset pulse held across a counting edge, released at a falling edge.
   task automatic resetPulse();
      busA.En = 1'b1; busA.Up = 1'b1; busA.Load = 1'b0;
      busB.En = 1'b1; busB.Up = 1'b1; busB.Load = 1'b0;
      #2;
      Resetn = 1'b0;
      #1;
      checkOutput("rst.A.Q",   busA.Q,   0);
      checkOutput("rst.A.Ovf", busA.Ovf, 0);
      checkOutput("rst.B.Q",   busB.Q,   0);
      checkOutput("rst.B.Ovf", busB.Ovf, 0);
      @(posedge Clk);
      #1;
      checkOutput("rstHold.A.Q", busA.Q, 0);
      checkOutput("rstHold.B.Q", busB.Q, 0);
      qA = 0; ovA = 0; qB = 0; ovB = 0;
      @(negedge Clk);
      Resetn = 1'b1;
   endtask

   initial begin
      Resetn = 1'b0;
      busA.En = 1'b0; busA.Up = 1'b0; busA.Load = 1'b0; busA.D = '0;
      busB.En = 1'b0; busB.Up = 1'b0; busB.Load = 1'b0; busB.D = '0;
      repeat (2) @(negedge Clk);
      Resetn = 1'b1;

      // Reset from a nonzero count, then count up out of reset.
      applyStimulus(1'b0, 1'b0, 1'b1, 7);
      resetPulse();
      applyStimulus(1'b1, 1'b1, 1'b0, 0);
      applyStimulus(1'b1, 1'b1, 1'b0, 0);

      // Up wrap 8,9,0,1 then down wrap 1,0,9,8.
      applyStimulus(1'b0, 1'b1, 1'b1, 8);
      repeat (4) applyStimulus(1'b1, 1'b1, 1'b0, 0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1);
      repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, 0);

      // Clamp, then load coinciding with a wrap condition.
      applyStimulus(1'b1, 1'b1, 1'b1, 13);
      applyStimulus(1'b1, 1'b1, 1'b1, 9);
      applyStimulus(1'b1, 1'b1, 1'b0, 0);

      // Hold at 5, then count 5->6.
      applyStimulus(1'b0, 1'b0, 1'b1, 5);
      repeat (4) applyStimulus(1'b0, 1'b1, 1'b0, 0);
      applyStimulus(1'b1, 1'b1, 1'b0, 0);

      // Full up sweep to exercise the mod-8 instance's 7->0 wrap.
      applyStimulus(1'b0, 1'b1, 1'b1, 0);
      repeat (12) applyStimulus(1'b1, 1'b1, 1'b0, 0);

      // Randomized traffic, loads kept rare so wraps occur.
      for (int i = 0; i < 400; i++) begin
         applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom),
                       1'($urandom_range(0, 9) == 0), int'($urandom_range(0, 15)));
         if (i == 200) resetPulse();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
